// File: rtl/weight_streamer.sv
// Weight streamer: reads consecutive weight words from a 1-cycle-latency BRAM
// and presents them as a valid/ready beat stream, tile_num*TN beats per command.
// Reads are credit-gated against a 4-entry skid FIFO, so consumer stalls never
// cause an overflow. TN must be a power of two.
module weight_streamer #(
    parameter int DW = 64,
    parameter int TN = 16,
    parameter int AW = 12,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [TW-1:0] tile_num,
    output logic          busy,
    output logic          done,
    output logic          tile_done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          t_valid,
    output logic [DW-1:0] t_data,
    input  logic          t_ready
);

    localparam int TNB   = $clog2(TN);
    localparam int CW    = TW + TNB;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_reg, state_next;

    logic [CW-1:0] total_reg;
    logic [CW-1:0] issued_reg;
    logic [CW-1:0] beats_reg;
    logic [AW-1:0] rd_addr_reg;
    logic [AW-1:0] mem_addr_reg;
    logic          mem_en_reg;
    logic          rvalid_reg;
    logic          tile_done_reg;

    logic [DW-1:0] fifo_mem [DEPTH];
    logic [1:0]    wr_ptr_reg;
    logic [1:0]    rd_ptr_reg;
    logic [2:0]    count_reg;

    logic          accept;
    logic [CW-1:0] cmd_total;
    logic [3:0]    credit_used;
    logic          issue;
    logic          push;
    logic          pop;
    logic          last_beat;
    logic          tile_last;

    // Full-width beat total so tile_num*TN never truncates.
    assign cmd_total   = CW'(tile_num) * CW'(TN);
    assign accept      = (state_reg == ST_IDLE) && start;

    // Words buffered plus reads still in the BRAM pipeline; a new read only
    // goes out when all of them are guaranteed a FIFO slot.
    assign credit_used = 4'(count_reg) + 4'(mem_en_reg) + 4'(rvalid_reg);
    assign issue       = (state_reg == ST_STREAM) && (issued_reg < total_reg)
                         && (credit_used < 4'(DEPTH));

    assign push        = rvalid_reg;
    assign pop         = t_valid && t_ready;
    assign last_beat   = pop && (beats_reg == total_reg - CW'(1));
    assign tile_last   = pop && (beats_reg[TNB-1:0] == TNB'(TN - 1));

    assign mem_en      = mem_en_reg;
    assign mem_addr    = mem_addr_reg;
    assign tile_done   = tile_done_reg;
    assign t_valid     = (count_reg != 3'd0);
    assign t_data      = fifo_mem[rd_ptr_reg];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and status outputs; busy drops as done rises.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (tile_num == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (last_beat) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, read issue pipeline and beat/tile bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_reg     <= '0;
            issued_reg    <= '0;
            beats_reg     <= '0;
            rd_addr_reg   <= '0;
            mem_addr_reg  <= '0;
            mem_en_reg    <= 1'b0;
            rvalid_reg    <= 1'b0;
            tile_done_reg <= 1'b0;
        end else begin
            mem_en_reg    <= issue;
            rvalid_reg    <= mem_en_reg;
            tile_done_reg <= tile_last;
            if (accept) begin
                total_reg   <= cmd_total;
                issued_reg  <= '0;
                beats_reg   <= '0;
                rd_addr_reg <= base_addr;
            end else begin
                if (issue) begin
                    issued_reg   <= issued_reg + CW'(1);
                    rd_addr_reg  <= rd_addr_reg + AW'(1);
                    mem_addr_reg <= rd_addr_reg;
                end
                if (pop) begin
                    beats_reg <= beats_reg + CW'(1);
                end
            end
        end
    end

    // Skid FIFO: BRAM data lands the cycle after the read is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= mem_rdata;
                wr_ptr_reg           <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + 3'(push) - 3'(pop);
        end
    end

endmodule

// File: tb/tb_weight_streamer.sv
// Bench for weight_streamer: BRAM model, queue-based reference of the expected
// beat/address sequence, per-cycle compare process and directed scenarios.
module tb_weight_streamer;

    localparam int DW = 64;
    localparam int TN = 16;
    localparam int AW = 12;
    localparam int TW = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [TW-1:0] tile_num  = '0;
    logic          busy;
    logic          done;
    logic          tile_done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          t_valid;
    logic [DW-1:0] t_data;
    logic          t_ready   = 1'b1;

    weight_streamer #(.DW(DW), .TN(TN), .AW(AW), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .tile_num  (tile_num),
        .busy      (busy),
        .done      (done),
        .tile_done (tile_done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .t_valid   (t_valid),
        .t_data    (t_data),
        .t_ready   (t_ready)
    );

    always #5 clk = ~clk;

    // BRAM model: mem[i] = i, one-cycle read latency.
    logic [DW-1:0] mem [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    end
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model state
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] got_q [$];
    bit            model_active = 0;
    bit            exp_done     = 0;
    bit            exp_tile     = 0;
    bit            exp_busy     = 0;
    bit            first_seen   = 1;
    bit            stalled_prev = 0;
    logic [DW-1:0] prev_data    = '0;
    int            first_due    = 0;
    int            beat_idx     = 0;
    int            issued       = 0;
    int            popped       = 0;
    int            done_cnt     = 0;
    int            tile_cnt     = 0;
    int            mem_en_cnt   = 0;
    bit            full_rate    = 1;
    bit            ready_rand   = 0;

    // Ready driver: held high, or random 50% when ready_rand is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            t_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Compare process: outputs sampled mid-cycle against the model.
    always @(negedge clk) begin
        bit            n_done;
        bit            n_tile;
        bit            n_busy;
        int            total;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        cyc++;
        if (!rst_n) begin
            chk(!(busy | done | tile_done | mem_en | t_valid) && mem_addr == '0 && t_data == '0,
                "reset_outputs", {busy, done, tile_done, mem_en, t_valid}, 0);
            exp_q.delete();
            addr_q.delete();
            model_active = 0; exp_done = 0; exp_tile = 0; exp_busy = 0;
            first_seen = 1; stalled_prev = 0; issued = 0; popped = 0;
        end else begin
            chk(done == exp_done, "done", done, exp_done);
            chk(tile_done == exp_tile, "tile_done", tile_done, exp_tile);
            chk(busy == exp_busy, "busy", busy, exp_busy);
            if (done) done_cnt++;
            if (tile_done) tile_cnt++;
            if (t_valid && exp_q.size() == 0) chk(0, "spurious_valid", t_data, 0);
            if (t_valid && !first_seen) begin
                chk(cyc == first_due, "first_latency", cyc, first_due);
                first_seen = 1;
            end
            if (stalled_prev) chk(t_valid && t_data == prev_data, "stall_hold", t_data, prev_data);
            if (full_rate && model_active && first_seen && exp_q.size() > 0)
                chk(t_valid, "no_bubble", t_valid, 1);
            if (mem_en) begin
                mem_en_cnt++;
                issued++;
                if (addr_q.size() == 0) chk(0, "spurious_read", mem_addr, 0);
                else begin
                    a = addr_q.pop_front();
                    chk(mem_addr == a, "read_addr", mem_addr, a);
                end
                chk(issued - popped <= 4, "unconsumed_reads", issued - popped, 4);
            end
            n_done = 0;
            n_tile = 0;
            n_busy = exp_busy;
            if (start && !model_active && !exp_done) begin
                if (tile_num == '0) n_done = 1;
                else begin
                    model_active = 1;
                    n_busy = 1;
                    total = int'(tile_num) * TN;
                    for (int k = 0; k < total; k++) begin
                        exp_q.push_back(mem[(int'(base_addr) + k) % (1 << AW)]);
                        addr_q.push_back(AW'(int'(base_addr) + k));
                    end
                    first_due  = cyc + 4;
                    first_seen = 0;
                    beat_idx   = 0;
                end
            end else if (t_valid && t_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(t_data == e, "beat_data", t_data, e);
                got_q.push_back(t_data);
                popped++;
                beat_idx++;
                if (beat_idx % TN == 0) n_tile = 1;
                if (exp_q.size() == 0) begin
                    n_done = 1;
                    n_busy = 0;
                    model_active = 0;
                end
            end
            stalled_prev = t_valid && !t_ready;
            prev_data    = t_data;
            exp_done     = n_done;
            exp_tile     = n_tile;
            exp_busy     = n_busy;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] b, input logic [TW-1:0] n);
        base_addr = b;
        tile_num  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic clear_stats();
        got_q.delete();
        done_cnt = 0;
        tile_cnt = 0;
        mem_en_cnt = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        chk(done_cnt > d0, name, k, budget);
        tick(2);
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(got_q.size() >= n, name, got_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // T1: one tile from 0x010 at full rate
        clear_stats();
        send(12'h010, 8'd1);
        wait_done(100, "t1_timeout");
        chk(got_q.size() == 16, "t1_beat_count", got_q.size(), 16);
        chk(got_q[0] == 64'h10, "t1_first_beat", got_q[0], 64'h10);
        chk(got_q[15] == 64'h1F, "t1_last_beat", got_q[15], 64'h1F);
        chk(done_cnt == 1, "t1_done_count", done_cnt, 1);
        chk(tile_cnt == 1, "t1_tile_count", tile_cnt, 1);
        chk(busy == 1'b0, "t1_busy_after", busy, 0);

        // T2: same command with random back-pressure
        ready_rand = 1;
        full_rate  = 0;
        tick(2);
        clear_stats();
        send(12'h010, 8'd1);
        wait_done(400, "t2_timeout");
        chk(got_q.size() == 16, "t2_beat_count", got_q.size(), 16);
        chk(got_q[7] == 64'h17, "t2_mid_beat", got_q[7], 64'h17);
        chk(done_cnt == 1, "t2_done_count", done_cnt, 1);
        ready_rand = 0;
        tick(2);
        full_rate  = 1;

        // T3: three tiles wrapping the address space
        clear_stats();
        send(12'hFF8, 8'd3);
        wait_done(300, "t3_timeout");
        chk(got_q.size() == 48, "t3_beat_count", got_q.size(), 48);
        chk(got_q[7] == 64'hFFF, "t3_pre_wrap", got_q[7], 64'hFFF);
        chk(got_q[8] == 64'h0, "t3_post_wrap", got_q[8], 64'h0);
        chk(got_q[47] == 64'h27, "t3_last_beat", got_q[47], 64'h27);
        chk(tile_cnt == 3, "t3_tile_count", tile_cnt, 3);

        // T4: empty command
        clear_stats();
        send(12'h123, 8'd0);
        wait_done(10, "t4_timeout");
        chk(mem_en_cnt == 0, "t4_no_reads", mem_en_cnt, 0);
        chk(got_q.size() == 0, "t4_no_beats", got_q.size(), 0);
        chk(done_cnt == 1, "t4_done_count", done_cnt, 1);

        // T5: second start mid-stream must be ignored
        clear_stats();
        send(12'h100, 8'd2);
        wait_beats(5, 100, "t5_beats_timeout");
        send(12'h200, 8'd1);
        wait_done(200, "t5_timeout");
        tick(20);
        chk(got_q.size() == 32, "t5_beat_count", got_q.size(), 32);
        chk(got_q[31] == 64'h11F, "t5_last_beat", got_q[31], 64'h11F);
        chk(done_cnt == 1, "t5_done_count", done_cnt, 1);

        // T6: reset at beat 7, then a fresh command
        clear_stats();
        send(12'h040, 8'd2);
        wait_beats(7, 100, "t6_beats_timeout");
        rst_n = 1'b0;
        #1;
        chk(!(busy | done | tile_done | mem_en | t_valid) && t_data == '0 && mem_addr == '0,
            "t6_reset_immediate", {busy, done, tile_done, mem_en, t_valid}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clear_stats();
        send(12'h300, 8'd1);
        wait_done(100, "t6_timeout");
        chk(got_q.size() == 16, "t6_beat_count", got_q.size(), 16);
        chk(got_q[0] == 64'h300, "t6_first_beat", got_q[0], 64'h300);
        chk(got_q[15] == 64'h30F, "t6_last_beat", got_q[15], 64'h30F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
